// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and an iterative shift-add multiplier.
// Optional macro ALU_PIPE_SAT_EN: signed ADD/SUB overflow saturates instead of wrapping.
module alu_pipe #(
  parameter int WIDTH         = 4,
  parameter int MUL_EN_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_HOLD
  } state_e;

  // The BUSY counter spans the WIDTH multiply steps plus the idle tail.
  localparam int              TOTAL = WIDTH + MUL_EN_CYCLES;
  localparam int              CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0]   LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0]   ITER  = CW'(WIDTH);

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] acc_step;
  logic               accept;
  logic               is_mul;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op_e'(op) == OP_MUL);
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = (result_q == '0);

  // Single-cycle operations, evaluated straight from the presented operands.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    sum_w    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    dif_w    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    case (op_e'(op))
      OP_ADD: begin
        alu_res  = sum_w[WIDTH-1:0];
        alu_cout = sum_w[WIDTH];
        alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = dif_w[WIDTH-1:0];
        alu_cout = dif_w[WIDTH];
        alu_ovf  = (a[WIDTH-1] == ~b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res  = {a[WIDTH-2:0], cin};
        alu_cout = a[WIDTH-1];
      end
      OP_CMP: begin
        alu_res  = {{(WIDTH-1){1'b0}}, (a < b)};
        alu_cout = (a == b);
      end
      default: ;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Only ADD/SUB can raise alu_ovf; the sign of a tells which rail was crossed.
    if (alu_ovf) begin
      alu_res = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            state_d  = S_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = S_HOLD;
            result_d = alu_res;
            cout_d   = alu_cout;
            ovf_d    = alu_ovf;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q < ITER) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == LAST) begin
          state_d  = S_HOLD;
          result_d = acc_d[WIDTH-1:0];
          cout_d   = |acc_d[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the multiplier registers are reset too, so an aborted multiply leaves nothing stale.
      state_q  <= S_IDLE;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed plan steps plus random ops against an integer model.
module tb_alu_pipe;

  localparam int W   = 4;
  localparam int MEC = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  alu_pipe #(.WIDTH(W), .MUL_EN_CYCLES(MEC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic with signed range checks.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] oa, input logic [W-1:0] ob,
                                 input logic oc);
    exp_t r;
    int ua, ub, sa, sb, c, u, s;
    ua = int'(oa);
    ub = int'(ob);
    c  = oc ? 1 : 0;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    r  = '0;
    case (o)
      3'b000: begin
        u = ua + ub + c;
        s = sa + sb + c;
        r.res = 4'(u % 16);
        r.co  = (u >= 16);
        r.ov  = (s > 7) || (s < -8);
`ifdef ALU_PIPE_SAT_EN
        if (r.ov) r.res = (s > 7) ? 4'h7 : 4'h8;
`endif
      end
      3'b001: begin
        u = ua - ub - c;
        s = sa - sb - c;
        r.res = 4'((u + 32) % 16);
        r.co  = (u < 0);
        r.ov  = (s > 7) || (s < -8);
`ifdef ALU_PIPE_SAT_EN
        if (r.ov) r.res = (s > 7) ? 4'h7 : 4'h8;
`endif
      end
      3'b010: r.res = oa & ob;
      3'b011: r.res = oa | ob;
      3'b100: r.res = oa ^ ob;
      3'b101: begin
        r.res = 4'((ua * 2 + c) % 16);
        r.co  = (ua >= 8);
      end
      3'b110: begin
        u = ua * ub;
        r.res = 4'(u % 16);
        r.co  = (u >= 16);
      end
      default: begin
        r.res = (ua < ub) ? 4'h1 : 4'h0;
        r.co  = (ua == ub);
      end
    endcase
    return r;
  endfunction

  // Presents one op (from IDLE or HOLD), checks latency and outputs, optionally stalls and drains.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oc, input int hold, input bit drain, input string tag);
    exp_t e;
    int   lat;
    int   exp_lat;
    e       = model(o, oa, ob, oc);
    exp_lat = (o == 3'b110) ? W + 1 + MEC : 1;
    op = o; a = oa; b = ob; cin = oc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, " in_ready_at_issue"}, 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, 32'(result), 32'(e.res));
    check({tag, " cout"}, 32'(cout), 32'(e.co));
    check({tag, " ovf"}, 32'(ovf), 32'(e.ov));
    check({tag, " zero"}, 32'(zero), 32'(e.res == '0));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold_result"}, 32'(result), 32'(e.res));
      check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    if (drain) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " drained"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; cin = 1'b0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    // ADD with signed overflow, SUB borrow, SUB to zero
    run_op(3'b000, 4'h7, 4'h1, 1'b0, 0, 1'b1, "add_7_1");
    run_op(3'b001, 4'h3, 4'h5, 1'b0, 0, 1'b1, "sub_3_5");
    run_op(3'b001, 4'h5, 4'h5, 1'b0, 0, 1'b1, "sub_5_5");

    // Multiply: high part nonzero, then fits
    run_op(3'b110, 4'h6, 4'h3, 1'b0, 0, 1'b1, "mul_6_3");
    run_op(3'b110, 4'h3, 4'h2, 1'b0, 0, 1'b1, "mul_3_2");

    // Back-pressure on AND, then XOR accepted in the same cycle the result drains
    op = 3'b010; a = 4'hC; b = 4'hA; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("bp and valid", 32'(out_valid), 32'd1);
    check("bp and result", 32'(result), 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp and held", 32'(result), 32'h8);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp still valid", 32'(out_valid), 32'd1);
    end
    op = 3'b100; a = 4'hF; b = 4'h1;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp in_ready raised", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp xor valid", 32'(out_valid), 32'd1);
    check("bp xor result", 32'(result), 32'hE);
    check("bp xor zero", 32'(zero), 32'd0);

    // From HOLD straight into a multiply, then drain
    run_op(3'b110, 4'h5, 4'h5, 1'b0, 1, 1'b1, "mul_from_hold");

    // Reset in the second BUSY cycle
    op = 3'b110; a = 4'h7; b = 4'h7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("midmul busy", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check("midmul out_valid", 32'(out_valid), 32'd0);
    check("midmul in_ready", 32'(in_ready), 32'd1);
    check("midmul result", 32'(result), 32'd0);
    check("midmul zero", 32'(zero), 32'd1);
    run_op(3'b000, 4'h1, 4'h1, 1'b0, 0, 1'b1, "add_after_rst");

    // Signed boundaries with carry-in
    run_op(3'b001, 4'h8, 4'h0, 1'b1, 0, 1'b1, "sub_min_cin");
    run_op(3'b000, 4'h8, 4'hF, 1'b1, 0, 1'b1, "add_neg_cin");
    run_op(3'b101, 4'h9, 4'h0, 1'b1, 0, 1'b1, "shl_msb");
    run_op(3'b111, 4'h4, 4'h4, 1'b0, 0, 1'b1, "cmp_eq");

    // Random ops with random stalls and back-to-back issue
    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("final drain", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor of the fixed 4-bit combinational ALU benchmarks.
- Accepts one operation per valid/ready handshake and returns a registered result plus flags on a second valid/ready handshake.
- Adds an iterative shift-add multiply, carry/borrow/overflow/zero flags and back-pressure.
- Sits between an operand source and a result sink in the evolved-circuit test harness as the sequential reference datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (legal 2..32).
- MUL_EN_CYCLES, 0, extra idle cycles inserted after multiply completes before out_valid (0 = none); models a slow multiplier.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept operands this cycle.
- op  input  3  operation code (see Behaviour).
- a  input  WIDTH  operand A (two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry/borrow in for ADD/SUB, fill bit for SHL.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  sink accepts result this cycle.
- result  output  WIDTH  operation result.
- cout  output  1  carry out / borrow / multiply high-part-nonzero.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow (ADD/SUB) or saturation (see Optional Feature), else 0.

Behaviour:
- Opcodes: 000 ADD a+b+cin; 001 SUB a-b-cin, cout=1 on borrow; 010 AND; 011 OR; 100 XOR; 101 SHL {a[WIDTH-2:0],cin}, cout=a[WIDTH-1]; 110 MUL low WIDTH bits of a*b unsigned, cout=1 iff upper WIDTH bits nonzero; 111 CMP result=1 if a<b unsigned else 0, cout=(a==b).
- cout=0 and ovf=0 for AND/OR/XOR/CMP-ovf. zero always reflects the registered result.
- FSM states: IDLE, BUSY (multiply iterating), HOLD (result valid).
- IDLE: in_ready=1. Accept on in_valid. A non-MUL op goes to HOLD next cycle (latency 1). MUL latches a and b, clears the accumulator and goes to BUSY.
- BUSY: one bit of b per cycle, LSB first. Exactly WIDTH cycles, then MUL_EN_CYCLES wait cycles, then HOLD. in_ready=0 throughout BUSY.
- HOLD: out_valid=1 and outputs stable until out_ready. in_ready=out_ready, so back-to-back throughput is 1 op/cycle for non-MUL ops.
- On out_ready with a simultaneous accept, load the new result and stay in HOLD (or go to BUSY for MUL). On out_ready without an accept, go to IDLE.
- in_valid while in_ready=0 is ignored. The source must hold its operands; the block does not buffer them.
- Reset (any state, including mid-MUL): state=IDLE, out_valid=0, result=0, cout=0, zero=1, ovf=0, multiply counter and accumulator cleared. The in-flight op is discarded.
- Arithmetic is computed in WIDTH+1 bits. Signed overflow is (a_msb==b'_msb)&&(res_msb!=a_msb), where b' is b for ADD and ~b for SUB.

Optional Feature:
- Macro ALU_PIPE_SAT_EN.
- Defined: ADD/SUB saturate. ADD/SUB signed overflow clamps result to 0111..1 (positive overflow) or 1000..0 (negative overflow); ovf=1 and cout keeps its unsaturated value. zero is evaluated after clamping.
- Undefined: results wrap modulo 2^WIDTH and ovf reports signed overflow only.

Test Plan:
- Reset then idle (WIDTH=4): rst=1 for 2 cycles -> out_valid=0, result=0, zero=1, in_ready=1.
- ADD: a=4'h7, b=4'h1, cin=0, out_ready=1 -> next cycle result=4'h8, cout=0, ovf=1, zero=0 (with SAT_EN: result=4'h7, ovf=1).
- SUB borrow: a=4'h3, b=4'h5, cin=0 -> result=4'hE, cout=1, ovf=0; then a=4'h5, b=4'h5 -> result=0, zero=1, cout=0.
- MUL: a=4'h6, b=4'h3 -> in_ready=0 for 4 cycles, out_valid on cycle 5, result=4'h2, cout=1. Repeat with a=4'h3, b=4'h2 -> result=4'h6, cout=0.
- Back-pressure: AND a=4'hC, b=4'hA, out_ready=0 for 3 cycles -> result=4'h8 held stable, in_ready=0. Raise out_ready with an XOR a=4'hF, b=4'h1 presented -> next result=4'hE, no idle bubble.
- Reset mid-MUL: start MUL, assert rst on the 2nd BUSY cycle -> next cycle IDLE, out_valid=0. A following ADD 1+1 returns 4'h2.
